multicycle_control: RTL and testbench

- Multi-cycle sequencer for the reduced RISC-V core. It replaces single-cycle flag decoding with a Moore FSM that steps each instruction through fetch, decode, execute and writeback/branch.
- Supported instructions: ADDI (OP-IMM, fn3=000) and BNE (BRANCH, fn3=001).
- Drives the existing datapath enables (RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc), adds PCWrite/IRWrite, and counts retired instructions.

---
 rtl/cpu_ctrl_pkg.sv | 40 ++++
 rtl/multicycle_control_if.sv | 30 +++
 rtl/retire_counter.sv | 20 ++
 rtl/multicycle_control.sv | 126 ++++++++++++
 tb/tb_multicycle_control.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer.
// Holds the FSM state encodings, the decoded opcode/fn3 constants of the
// supported instructions (ADDI, BNE) and the datapath-control bundle that
// the output decoder fills in for each state.
package cpu_ctrl_pkg;

    // State encodings are kept as plain 3-bit constants so that the raw
    // register value can be exported on state_dbg unchanged.
    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC_I = 3'd2;
    localparam logic [2:0] WB_I   = 3'd3;
    localparam logic [2:0] BRANCH = 3'd4;
    localparam logic [2:0] TRAP   = 3'd5;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    typedef struct packed {
        logic irwrite;
        logic pcwrite;
        logic regwrite;
        logic aluctrl;
        logic alusrc;
        logic immsrc;
        logic pcsrc;
    } ctrl_t;

    function automatic logic is_addi(input logic [6:0] op, input logic [2:0] f3);
        return (op == OP_IMM) && (f3 == F3_ADDI);
    endfunction

    function automatic logic is_bne(input logic [6:0] op, input logic [2:0] f3);
        return (op == OP_BRANCH) && (f3 == F3_BNE);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bus between the multi-cycle sequencer and the datapath.
//   instr, imem_ready : instruction word and its valid flag from imem
//   EQ                : rs1 != rs2 comparison result (BNE taken)
//   IRWrite, PCWrite, RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc :
//                       datapath enables driven by the sequencer
// master = sequencer side, slave = datapath/memory side.
interface multicycle_control_if #(
    parameter int unsigned ADDRESS_WIDTH = 32
);
    logic [ADDRESS_WIDTH-1:0] instr;
    logic                     imem_ready;
    logic                     EQ;
    logic                     IRWrite;
    logic                     PCWrite;
    logic                     RegWrite;
    logic                     ALUctrl;
    logic                     ALUsrc;
    logic                     ImmSrc;
    logic                     PCsrc;

    modport master (
        input  instr, imem_ready, EQ,
        output IRWrite, PCWrite, RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc
    );

    modport slave (
        output instr, imem_ready, EQ,
        input  IRWrite, PCWrite, RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc
    );
endinterface

// File: rtl/retire_counter.sv
// Retired-instruction counter.
//   clk, rst : clock, asynchronous active-high reset (clears count)
//   en       : increment by one on the next rising edge
//   count    : running total, wraps modulo 2^WIDTH
module retire_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle Moore sequencer for the reduced RISC-V core (ADDI, BNE).
// Steps each instruction through FETCH -> DECODE -> EXEC_I -> WB_I or
// FETCH -> DECODE -> BRANCH; anything else lands in a sticky TRAP.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : instruction/EQ inputs and datapath enables (master side)
//   illegal   : sticky flag, set on entry to TRAP
//   retired   : instructions completed since reset
//   state_dbg : raw state encoding
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_control_if.master  bus,
    output logic                  illegal,
    output logic [CNT_WIDTH-1:0]  retired,
    output logic [2:0]            state_dbg
);
    logic [2:0] state;
    logic [2:0] state_next;
    logic [6:0] opcode_q;
    logic [2:0] fn3_q;
    ctrl_t      ctrl;
    logic       retire_en;

    // Only opcode and fn3 are decoded; the remaining fields belong to the
    // datapath and are deliberately ignored here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.instr[ADDRESS_WIDTH-1:15], bus.instr[11:7]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            opcode_q <= '0;
            fn3_q    <= '0;
            illegal  <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == FETCH) && bus.imem_ready) begin
                opcode_q <= bus.instr[6:0];
                fn3_q    <= bus.instr[14:12];
            end
            if (state_next == TRAP) begin
                illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = TRAP;
        case (state)
            FETCH:   state_next = bus.imem_ready ? DECODE : FETCH;
            DECODE: begin
                if (is_addi(opcode_q, fn3_q)) begin
                    state_next = EXEC_I;
                end else if (is_bne(opcode_q, fn3_q)) begin
                    state_next = BRANCH;
                end else begin
                    state_next = TRAP;
                end
            end
            EXEC_I:  state_next = WB_I;
            WB_I:    state_next = FETCH;
            BRANCH:  state_next = FETCH;
            TRAP:    state_next = TRAP;
            default: state_next = TRAP;
        endcase
    end

    // Moore decode; PCsrc in BRANCH follows EQ combinationally. While rst
    // is high the state already reads FETCH, so the enables are forced low
    // explicitly to keep IRWrite from following imem_ready during reset.
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.irwrite = bus.imem_ready;
            end
            EXEC_I: begin
                ctrl.alusrc  = 1'b1;
                ctrl.immsrc  = 1'b1;
                ctrl.aluctrl = 1'b0;
            end
            WB_I: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.immsrc   = 1'b1;
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsrc    = 1'b0;
            end
            BRANCH: begin
                ctrl.aluctrl = 1'b1;
                ctrl.immsrc  = 1'b0;
                ctrl.pcwrite = 1'b1;
                ctrl.pcsrc   = bus.EQ;
            end
            default: ctrl = '0;
        endcase
        if (rst) begin
            ctrl = '0;
        end
    end

    assign bus.IRWrite  = ctrl.irwrite;
    assign bus.PCWrite  = ctrl.pcwrite;
    assign bus.RegWrite = ctrl.regwrite;
    assign bus.ALUctrl  = ctrl.aluctrl;
    assign bus.ALUsrc   = ctrl.alusrc;
    assign bus.ImmSrc   = ctrl.immsrc;
    assign bus.PCsrc    = ctrl.pcsrc;
    assign state_dbg    = state;

    assign retire_en = (state == WB_I) || (state == BRANCH);

    retire_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_retire (
        .clk   (clk),
        .rst   (rst),
        .en    (retire_en),
        .count (retired)
    );
endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int unsigned CW = 3;

    // Enable vector order: {IRWrite, PCWrite, RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc}
    localparam logic [6:0] E_NONE  = 7'b0000000;
    localparam logic [6:0] E_FETCH = 7'b1000000;
    localparam logic [6:0] E_EXEC  = 7'b0000110;
    localparam logic [6:0] E_WB    = 7'b0110110;
    localparam logic [6:0] E_BR1   = 7'b0101001;
    localparam logic [6:0] E_BR0   = 7'b0101000;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_BNE  = 32'hFE209EE3;
    localparam logic [31:0] I_RTYP = 32'h00000033;

    typedef struct packed {
        logic [2:0]    st;
        logic [6:0]    en;
        logic          ill;
        logic [CW-1:0] ret;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          illegal;
    logic [CW-1:0] retired;
    logic [2:0]    state_dbg;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    logic [CW-1:0] exp_ret;

    multicycle_control_if #(.ADDRESS_WIDTH(32)) bus ();

    multicycle_control #(
        .ADDRESS_WIDTH (32),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .illegal   (illegal),
        .retired   (retired),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [2:0] st, input logic [6:0] en,
                        input logic ill, input logic [CW-1:0] ret);
        exp_t e;
        e.st  = st;
        e.en  = en;
        e.ill = ill;
        e.ret = ret;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check();
        exp_t       e;
        string      t;
        logic [6:0] en_obs;
        n_cmp++;
        assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected >0");
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            en_obs = {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.ALUctrl,
                      bus.ALUsrc, bus.ImmSrc, bus.PCsrc};
            n_cmp++;
            assert (state_dbg === e.st) else begin
                n_fail++;
                $error("FAIL %s.state: observed %0d expected %0d", t, state_dbg, e.st);
            end
            n_cmp++;
            assert (en_obs === e.en) else begin
                n_fail++;
                $error("FAIL %s.enables: observed %b expected %b", t, en_obs, e.en);
            end
            n_cmp++;
            assert (illegal === e.ill) else begin
                n_fail++;
                $error("FAIL %s.illegal: observed %b expected %b", t, illegal, e.ill);
            end
            n_cmp++;
            assert (retired === e.ret) else begin
                n_fail++;
                $error("FAIL %s.retired: observed %0d expected %0d", t, retired, e.ret);
            end
        end
    endtask

    // Drive inputs, record the expectation, sample 1 ns later (mid low phase).
    task automatic probe(input string tag, input logic r, input logic [31:0] ins,
                         input logic rdy, input logic eq, input logic [2:0] st,
                         input logic [6:0] en, input logic ill, input logic [CW-1:0] ret);
        rst            = r;
        bus.instr      = ins;
        bus.imem_ready = rdy;
        bus.EQ         = eq;
        push(tag, st, en, ill, ret);
        #1;
        check();
    endtask

    task automatic cyc(input string tag, input logic r, input logic [31:0] ins,
                       input logic rdy, input logic eq, input logic [2:0] st,
                       input logic [6:0] en, input logic ill, input logic [CW-1:0] ret);
        probe(tag, r, ins, rdy, eq, st, en, ill, ret);
        @(negedge clk);
    endtask

    task automatic run_addi(input string tag);
        cyc({tag, ".fetch"},  1'b0, I_ADDI, 1'b1, 1'b0, 3'd0, E_FETCH, 1'b0, exp_ret);
        cyc({tag, ".decode"}, 1'b0, I_ADDI, 1'b1, 1'b0, 3'd1, E_NONE,  1'b0, exp_ret);
        cyc({tag, ".exec"},   1'b0, I_ADDI, 1'b1, 1'b0, 3'd2, E_EXEC,  1'b0, exp_ret);
        cyc({tag, ".wb"},     1'b0, I_ADDI, 1'b1, 1'b0, 3'd3, E_WB,    1'b0, exp_ret);
        exp_ret = exp_ret + 1'b1;
    endtask

    task automatic run_bne(input string tag, input logic eq);
        cyc({tag, ".fetch"},  1'b0, I_BNE, 1'b1, eq, 3'd0, E_FETCH, 1'b0, exp_ret);
        cyc({tag, ".decode"}, 1'b0, I_BNE, 1'b1, eq, 3'd1, E_NONE,  1'b0, exp_ret);
        cyc({tag, ".branch"}, 1'b0, I_BNE, 1'b1, eq, 3'd4, eq ? E_BR1 : E_BR0, 1'b0, exp_ret);
        exp_ret = exp_ret + 1'b1;
    endtask

    initial begin
        exp_ret = '0;

        // Reset with random instruction and imem_ready high: IRWrite must stay 0.
        cyc("reset0", 1'b1, $urandom, 1'b1, 1'b1, 3'd0, E_NONE, 1'b0, '0);
        cyc("reset1", 1'b1, $urandom, 1'b1, 1'b1, 3'd0, E_NONE, 1'b0, '0);

        run_addi("addi");

        // BNE taken: PCsrc follows EQ combinationally within BRANCH.
        cyc("bne1.fetch",  1'b0, I_BNE, 1'b1, 1'b1, 3'd0, E_FETCH, 1'b0, exp_ret);
        cyc("bne1.decode", 1'b0, I_BNE, 1'b1, 1'b1, 3'd1, E_NONE,  1'b0, exp_ret);
        probe("bne1.branch_eq1", 1'b0, I_BNE, 1'b1, 1'b1, 3'd4, E_BR1, 1'b0, exp_ret);
        probe("bne1.branch_eq0", 1'b0, I_BNE, 1'b1, 1'b0, 3'd4, E_BR0, 1'b0, exp_ret);
        bus.EQ = 1'b1;
        @(negedge clk);
        exp_ret = exp_ret + 1'b1;

        run_bne("bne0", 1'b0);

        // Stall in FETCH for 3 cycles.
        for (int i = 0; i < 3; i++)
            cyc("stall", 1'b0, I_ADDI, 1'b0, 1'b0, 3'd0, E_NONE, 1'b0, exp_ret);

        // ADDI with instr/imem_ready disturbed after FETCH: no effect.
        cyc("addi_s.fetch",  1'b0, I_ADDI, 1'b1, 1'b0, 3'd0, E_FETCH, 1'b0, exp_ret);
        cyc("addi_s.decode", 1'b0, I_RTYP, 1'b0, 1'b0, 3'd1, E_NONE,  1'b0, exp_ret);
        cyc("addi_s.exec",   1'b0, I_RTYP, 1'b0, 1'b1, 3'd2, E_EXEC,  1'b0, exp_ret);
        cyc("addi_s.wb",     1'b0, I_BNE,  1'b0, 1'b1, 3'd3, E_WB,    1'b0, exp_ret);
        exp_ret = exp_ret + 1'b1;

        // Counter wrap: 4 -> 5,6,7,0 with a 3-bit counter.
        for (int i = 0; i < 4; i++)
            run_bne("wrap", i[0]);

        // Illegal instruction: sticky TRAP with illegal=1, no PCWrite.
        cyc("ill.fetch",  1'b0, I_RTYP, 1'b1, 1'b0, 3'd0, E_FETCH, 1'b0, exp_ret);
        cyc("ill.decode", 1'b0, I_RTYP, 1'b1, 1'b0, 3'd1, E_NONE,  1'b0, exp_ret);
        for (int i = 0; i < 12; i++)
            cyc("ill.trap", 1'b0, (i % 2 == 0) ? I_ADDI : I_BNE, 1'b1, i[1], 3'd5, E_NONE, 1'b1, exp_ret);
        exp_ret = '0;
        probe("ill.rst_async", 1'b1, I_ADDI, 1'b1, 1'b0, 3'd0, E_NONE, 1'b0, exp_ret);
        @(negedge clk);

        // Reset during WB_I aborts the ADDI without retiring it.
        cyc("mid.fetch",  1'b0, I_ADDI, 1'b1, 1'b0, 3'd0, E_FETCH, 1'b0, exp_ret);
        cyc("mid.decode", 1'b0, I_ADDI, 1'b1, 1'b0, 3'd1, E_NONE,  1'b0, exp_ret);
        cyc("mid.exec",   1'b0, I_ADDI, 1'b1, 1'b0, 3'd2, E_EXEC,  1'b0, exp_ret);
        probe("mid.wb",   1'b0, I_ADDI, 1'b1, 1'b0, 3'd3, E_WB,    1'b0, exp_ret);
        probe("mid.rst",  1'b1, I_ADDI, 1'b1, 1'b0, 3'd0, E_NONE,  1'b0, exp_ret);
        @(negedge clk);
        cyc("mid.rst_hold", 1'b1, I_ADDI, 1'b1, 1'b0, 3'd0, E_NONE, 1'b0, exp_ret);

        run_addi("restart");
        cyc("final.fetch", 1'b0, I_ADDI, 1'b0, 1'b0, 3'd0, E_NONE, 1'b0, exp_ret);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
